// File: rtl/mem_responder.sv
// Memory-side responder for the load/store port: one request at a time over valid/ready,
// word-addressed storage with a fixed access latency, response held until consumed.
module mem_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem_q [DEPTH];

  logic                  accept;
  logic                  commit;
  logic                  acc_write;
  logic [31:0]           acc_addr;
  logic [31:0]           acc_wdata;
  logic                  acc_err;
  logic [DEPTH_LOG2-1:0] acc_idx;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign accept     = req_valid && req_ready;

  // A zero-latency access commits on its acceptance edge, before the capture
  // registers hold the request, so the live inputs are used in IDLE.
  assign acc_write = (state_q == IDLE) ? req_write : write_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign acc_idx   = acc_addr[DEPTH_LOG2+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) ||
                     ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        err_q   <= acc_err;
        rdata_q <= (acc_write || acc_err) ? 32'd0 : mem_q[acc_idx];
      end
    end
  end

  // NOTE: storage has no reset; contents survive rst, and gating the write with
  // rst drops a store whose commit edge coincides with reset.
  always_ff @(posedge clk) begin
    if (!rst && commit && acc_write && !acc_err) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three builds (LATENCY 2, 0, 3) driven one request at a time,
// expected responses queued at acceptance and compared when the response appears.
module tb_mem_responder;

  logic        clk;
  logic        rst        [3];
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic        resp_valid [3];
  logic        resp_ready [3];
  logic [31:0] resp_rdata [3];
  logic        resp_err   [3];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [3][256];
  int          lat [3] = '{2, 0, 3};
  int          acc_cyc [3];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .DEPTH_LOG2(8),
      .LATENCY   (g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  // Drive a request at the current negedge, wait for acceptance, queue its expectation.
  task automatic issue(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] wd, input bit dropped);
    int   n;
    logic err;
    exp_t e;
    req_valid[d] = 1'b1;
    req_write[d] = w;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (!req_ready[d]) begin
      n_bad++;
      $display("FAIL accept_timeout dut%0d: req_ready=%b, required 1", d, req_ready[d]);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc[d]   = cyc;
    req_valid[d] = 1'b0;
    req_write[d] = ~w;
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    err = (a[1:0] != 2'b00) || (a[31:10] != 22'd0);
    e.err   = err;
    e.rdata = (w || err) ? 32'd0 : model[d][a[9:2]];
    if (!dropped) begin
      sb.push_back(e);
      if (w && !err) model[d][a[9:2]] = wd;
    end
  endtask

  // Wait for resp_valid, checking its latency and the queued result.
  task automatic wait_resp(input int d);
    int   n;
    exp_t e;
    n = 0;
    while (!resp_valid[d] && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n !== lat[d]) begin
      n_bad++;
      $display("FAIL resp_latency dut%0d: got %0d cycles, required %0d", d, n, lat[d]);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard dut%0d: response with no expectation queued", d);
      return;
    end
    e = sb.pop_front();
    if (resp_rdata[d] !== e.rdata || resp_err[d] !== e.err) begin
      n_bad++;
      $display("FAIL resp_data dut%0d: rdata=%h err=%b, required rdata=%h err=%b",
               d, resp_rdata[d], resp_err[d], e.rdata, e.err);
    end
  endtask

  task automatic consume(input int d);
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (resp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1) begin
      n_bad++;
      $display("FAIL back_to_idle dut%0d: resp_valid=%b req_ready=%b, required 0/1",
               d, resp_valid[d], req_ready[d]);
    end
  endtask

  task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd);
    issue(d, w, a, wd, 1'b0);
    wait_resp(d);
    consume(d);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; resp_ready[d] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (req_ready[d] !== 1'b1 || resp_valid[d] !== 1'b0 ||
          resp_rdata[d] !== 32'd0 || resp_err[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, required 1/0/0/0",
                 d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
      end
    end
  endtask

  task automatic test_store_load;
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF);
    xfer(0, 1'b0, 32'h10, 32'h0);
    xfer(0, 1'b1, 32'h3FC, 32'h600DF00D);
    xfer(0, 1'b0, 32'h3FC, 32'h0);
  endtask

  task automatic test_errors;
    xfer(0, 1'b1, 32'h0, 32'hCAFEF00D);
    xfer(0, 1'b0, 32'h13, 32'h0);
    xfer(0, 1'b1, 32'h400, 32'h11111111);
    xfer(0, 1'b1, 32'h2, 32'h22222222);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0);
    xfer(0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_backpressure;
    resp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h10, 32'h0, 1'b0);
    wait_resp(0);
    req_valid[0] = 1'b1;
    req_write[0] = 1'b1;
    req_addr[0]  = 32'h10;
    req_wdata[0] = 32'h0BAD0BAD;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hDEADBEEF || req_ready[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_resp: valid=%b rdata=%h ready=%b, required 1/deadbeef/0",
                 resp_valid[0], resp_rdata[0], req_ready[0]);
      end
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    consume(0);
    xfer(0, 1'b0, 32'h10, 32'h0);
  endtask

  task automatic test_zero_latency;
    int first;
    xfer(1, 1'b1, 32'h4, 32'h1234);
    first = acc_cyc[1];
    xfer(1, 1'b0, 32'h4, 32'h0);
    n_cmp++;
    if (acc_cyc[1] - first !== 2) begin
      n_bad++;
      $display("FAIL b2b_spacing: got %0d cycles, required 2", acc_cyc[1] - first);
    end
    xfer(1, 1'b1, 32'h3F8, 32'hA5A5A5A5);
    first = acc_cyc[1];
    xfer(1, 1'b0, 32'h3F8, 32'h0);
    n_cmp++;
    if (acc_cyc[1] - first !== 2) begin
      n_bad++;
      $display("FAIL b2b_spacing2: got %0d cycles, required 2", acc_cyc[1] - first);
    end
  endtask

  task automatic test_back_to_back;
    int first;
    xfer(0, 1'b1, 32'h20, 32'h01020304);
    first = acc_cyc[0];
    xfer(0, 1'b0, 32'h20, 32'h0);
    n_cmp++;
    if (acc_cyc[0] - first !== 4) begin
      n_bad++;
      $display("FAIL b2b_spacing_lat2: got %0d cycles, required 4", acc_cyc[0] - first);
    end
  endtask

  task automatic test_reset_mid_op;
    bit seen;
    xfer(2, 1'b1, 32'h8, 32'h11112222);
    // Store accepted, then reset while still waiting: it must never commit.
    issue(2, 1'b1, 32'h8, 32'hAAAA5555, 1'b1);
    rst[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b0;
    n_cmp++;
    if (resp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_in_wait: valid=%b ready=%b, required 0/1", resp_valid[2], req_ready[2]);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (resp_valid[2]) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_no_resp: resp_valid seen=%b, required 0", seen);
    end
    xfer(2, 1'b0, 32'h8, 32'h0);
    // Committed store, reset while the response waits.
    resp_ready[2] = 1'b0;
    issue(2, 1'b1, 32'h8, 32'h5A5A0F0F, 1'b0);
    wait_resp(2);
    rst[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[2] = 1'b0;
    resp_ready[2] = 1'b1;
    n_cmp++;
    if (resp_valid[2] !== 1'b0 || req_ready[2] !== 1'b1 || resp_rdata[2] !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_in_resp: valid=%b ready=%b rdata=%h, required 0/1/0",
               resp_valid[2], req_ready[2], resp_rdata[2]);
    end
    xfer(2, 1'b0, 32'h8, 32'h0);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_zero_latency();
    test_reset_mid_op();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
